// File: rtl/prj_hamming_apb_pkg.sv
// rtl/prj_hamming_apb_pkg.sv - shared types, defaults and helpers for the APB Hamming reset stage
package prj_hamming_apb_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RUN       = 2'd2,
    ST_SWRST     = 2'd3
  } rst_state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_HOLD_CYCLES = 1024;
  localparam int DEF_LOCK_FILTER = 16;
  localparam int DEF_SW_HOLD     = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/prj_hamming_apb_sync.sv
// rtl/prj_hamming_apb_sync.sv - flop-chain synchronizer with asynchronous active-low clear
module prj_hamming_apb_sync
  import prj_hamming_apb_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/prj_hamming_apb_rst_ctrl.sv
// rtl/prj_hamming_apb_rst_ctrl.sv - lock-qualified fabric reset sequencer for the APB Hamming subsystem
module prj_hamming_apb_rst_ctrl
  import prj_hamming_apb_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int LOCK_FILTER = DEF_LOCK_FILTER,
  parameter int SW_HOLD     = DEF_SW_HOLD
) (
  input  logic PCLK,
  input  logic PRESETN,
  input  logic FCCC_LOCK,
  input  logic SW_RST_REQ,
  output logic RST_SYNC_N,
  output logic FAB_RESET_N,
  output logic READY,
  output logic LOCK_LOST
);

  localparam int CNT_W = clog2(max3(HOLD_CYCLES, LOCK_FILTER, SW_HOLD) + 1);
  localparam logic [CNT_W-1:0] LF_LAST   = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SW_HOLD - 1);

  logic             rst_sync_n;
  logic             lock_s;
  rst_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             fab_reset_n_q;
  logic             ready_q;
  logic             lock_lost_q;

  prj_hamming_apb_sync #(.STAGES(SYNC_STAGES)) u_rst_sync (
    .clk   (PCLK),
    .clr_n (PRESETN),
    .d     (1'b1),
    .q     (rst_sync_n)
  );

  prj_hamming_apb_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (PCLK),
    .clr_n (rst_sync_n),
    .d     (FCCC_LOCK),
    .q     (lock_s)
  );

  // Outputs default low each cycle and are only raised on entering or staying in RUN,
  // so FAB_RESET_N/READY are registered copies of "next state is RUN".
  always_ff @(posedge PCLK or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state         <= ST_WAIT_LOCK;
      cnt           <= '0;
      fab_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      fab_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
      case (state)
        ST_WAIT_LOCK: begin
          if (!lock_s) begin
            cnt <= '0;
          end else if (cnt == LF_LAST) begin
            cnt   <= '0;
            state <= ST_HOLD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (!lock_s) begin
            cnt   <= '0;
            state <= ST_WAIT_LOCK;
          end else if (cnt == HOLD_LAST) begin
            cnt           <= '0;
            state         <= ST_RUN;
            fab_reset_n_q <= 1'b1;
            ready_q       <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          // Lock loss takes priority over a coincident software request.
          if (!lock_s) begin
            cnt         <= '0;
            lock_lost_q <= 1'b1;
            state       <= ST_WAIT_LOCK;
          end else if (SW_RST_REQ) begin
            cnt   <= '0;
            state <= ST_SWRST;
          end else begin
            fab_reset_n_q <= 1'b1;
            ready_q       <= 1'b1;
          end
        end
        ST_SWRST: begin
          if (!lock_s) begin
            cnt   <= '0;
            state <= ST_WAIT_LOCK;
          end else if (cnt == SW_LAST) begin
            cnt   <= '0;
            state <= ST_HOLD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_WAIT_LOCK;
        end
      endcase
    end
  end

  assign RST_SYNC_N  = rst_sync_n;
  assign FAB_RESET_N = fab_reset_n_q;
  assign READY       = ready_q;
  assign LOCK_LOST   = lock_lost_q;

endmodule
